seq_divider_32: RTL and testbench

SEQ_DIVIDER_32 -- requirements
Module: seq_divider_32

---
 rtl/seq_divider_32.sv | 146 ++++++++++++++
 tb/tb_seq_divider_32.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// Latency: done pulses WIDTH+1 edges after the sampling edge; 1 edge for divide-by-zero.
// Backpressure: start is sampled only when not busy; start during RUN is ignored.
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    // Partial remainder stays strictly below the divisor, so WIDTH bits suffice between steps.
    logic [WIDTH-1:0] rem_q;
    // Holds the dividend magnitude initially; quotient bits shift in from the right.
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand signs and magnitudes; in unsigned mode the operands pass through untouched.
    always_comb begin
        a_neg = signed_op & dividend[WIDTH-1];
        b_neg = signed_op & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag = b_neg ? (~divisor + WIDTH'(1)) : divisor;
    end

    // One restoring step plus the final sign fix-up applied on the completing edge.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        quo_fix = q_neg_q ? (~quo_d + WIDTH'(1)) : quo_d;
        rem_fix = r_neg_q ? (~rem_d + WIDTH'(1)) : rem_d;
    end

    // Control FSM with datapath and registered outputs; done trails the DONE state by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // No iterations needed: publish the fixed divide-by-zero result now.
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Last step: results become visible only here, never mid-run.
                        quotient_q  <= quo_fix;
                        remainder_q <= rem_fix;
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32 at WIDTH=32 with hand-computed expected results.
// Checks latency, results, hold behaviour, ignored restarts, back-to-back and reset abort.
// Outputs are sampled 1ns after the rising edge; inputs change on the falling edge.
module tb_seq_divider_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total;
    int bad;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; returns 1ns after the edge that samples it.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen high; -1 if the budget runs out.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quot: got %h want 00000000", quotient); end
        total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_rem: got %h want 00000000", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int n;
        start_op(1'b0, 32'd100, 32'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL u100_busy: got %b want 1", busy); end
        wait_done(n);
        total++; if (n !== 33) begin bad++; $display("FAIL u100_latency: got %0d want 33", n); end
        total++; if (quotient !== 32'd14) begin bad++; $display("FAIL u100_quot: got %h want 0000000e", quotient); end
        total++; if (remainder !== 32'd2) begin bad++; $display("FAIL u100_rem: got %h want 00000002", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL u100_dbz: got %b want 0", div_by_zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL u100_busy_end: got %b want 0", busy); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL u100_done_width: got %b want 0", done); end
        total++; if (quotient !== 32'd14) begin bad++; $display("FAIL u100_hold: got %h want 0000000e", quotient); end

        start_op(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        total++; if (quotient !== 32'h0FFF_FFFF) begin bad++; $display("FAIL uffff_quot: got %h want 0fffffff", quotient); end
        total++; if (remainder !== 32'hF) begin bad++; $display("FAIL uffff_rem: got %h want 0000000f", remainder); end

        start_op(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        total++; if (quotient !== 32'h7FFF_FFFC) begin bad++; $display("FAIL ufff9_quot: got %h want 7ffffffc", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL ufff9_rem: got %h want 00000001", remainder); end
    endtask

    task automatic test_signed();
        int n;
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        total++; if (n !== 33) begin bad++; $display("FAIL sm7_latency: got %0d want 33", n); end
        total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sm7_quot: got %h want fffffffd", quotient); end
        total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sm7_rem: got %h want ffffffff", remainder); end

        start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(n);
        total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL s7m2_quot: got %h want fffffffd", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL s7m2_rem: got %h want 00000001", remainder); end

        start_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done(n);
        total++; if (quotient !== 32'd3) begin bad++; $display("FAIL sm7m2_quot: got %h want 00000003", quotient); end
        total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sm7m2_rem: got %h want ffffffff", remainder); end
    endtask

    task automatic test_div_zero();
        int n;
        start_op(1'b0, 32'h1234, 32'h0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy: got %b want 0", busy); end
        wait_done(n);
        total++; if (n !== 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", n); end
        total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot: got %h want ffffffff", quotient); end
        total++; if (remainder !== 32'h1234) begin bad++; $display("FAIL dz_rem: got %h want 00001234", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end

        start_op(1'b1, 32'hFFFF_FF00, 32'h0);
        wait_done(n);
        total++; if (remainder !== 32'hFFFF_FF00) begin bad++; $display("FAIL dzs_rem: got %h want ffffff00", remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dzs_flag: got %b want 1", div_by_zero); end
    endtask

    task automatic test_overflow();
        int n;
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quot: got %h want 80000000", quotient); end
        total++; if (remainder !== 32'h0) begin bad++; $display("FAIL ovf_rem: got %h want 00000000", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_start_ignored();
        int n;
        start_op(1'b0, 32'd1000, 32'd10);
        repeat (10) @(posedge clk);
        #1;
        total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL ign_hold_quot: got %h want 80000000", quotient); end
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        total++; if (n !== 22) begin bad++; $display("FAIL ign_latency: got %0d want 22", n); end
        total++; if (quotient !== 32'd100) begin bad++; $display("FAIL ign_quot: got %h want 00000064", quotient); end
        total++; if (remainder !== 32'd0) begin bad++; $display("FAIL ign_rem: got %h want 00000000", remainder); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(1'b0, 32'd50, 32'd5);
        repeat (32) @(posedge clk);
        #1;
        total++; if (quotient !== 32'd10) begin bad++; $display("FAIL b2b_first_quot: got %h want 0000000a", quotient); end
        @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy: got %b want 1", busy); end
        wait_done(n);
        total++; if (n !== 33) begin bad++; $display("FAIL b2b_latency: got %0d want 33", n); end
        total++; if (quotient !== 32'd19) begin bad++; $display("FAIL b2b_quot: got %h want 00000013", quotient); end
        total++; if (remainder !== 32'd1) begin bad++; $display("FAIL b2b_rem: got %h want 00000001", remainder); end
    endtask

    task automatic test_reset_abort();
        int n;
        logic seen;
        start_op(1'b0, 32'd12345, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (quotient !== 32'h0) begin bad++; $display("FAIL abort_quot: got %h want 00000000", quotient); end
        total++; if (remainder !== 32'h0) begin bad++; $display("FAIL abort_rem: got %h want 00000000", remainder); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
        start_op(1'b0, 32'd9, 32'd3);
        wait_done(n);
        total++; if (n !== 33) begin bad++; $display("FAIL post_latency: got %0d want 33", n); end
        total++; if (quotient !== 32'd3) begin bad++; $display("FAIL post_quot: got %h want 00000003", quotient); end
        total++; if (remainder !== 32'd0) begin bad++; $display("FAIL post_rem: got %h want 00000000", remainder); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'h0;
        divisor   = 32'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
